// File: rtl/multichannel_gain_ramp_if.sv
// Frame-level bus for the multichannel gain ramp: sample/gain/mute strobe in,
// gained samples and status out.
interface multichannel_gain_ramp_if #(
   parameter int NUM_CH = 8,
   parameter int DATA_W = 32,
   parameter int GAIN_W = 16
);
   logic                     in_valid;
   logic [NUM_CH*DATA_W-1:0] sample_in;
   logic [NUM_CH*GAIN_W-1:0] gain_tgt;
   logic [NUM_CH-1:0]        mute;
   logic                     clr_overrun;
   logic [NUM_CH*DATA_W-1:0] vol_out;
   logic                     out_valid;
   logic                     busy;
   logic                     overrun;

   modport master (
      output in_valid, sample_in, gain_tgt, mute, clr_overrun,
      input  vol_out, out_valid, busy, overrun
   );

   modport slave (
      input  in_valid, sample_in, gain_tgt, mute, clr_overrun,
      output vol_out, out_valid, busy, overrun
   );
endinterface

// File: rtl/multichannel_gain_ramp.sv
// Per-channel gain stage with linear gain ramping, mute, saturation and overrun
// detection; one shared two-stage multiplier is time-multiplexed across channels.
module multichannel_gain_ramp #(
   parameter int NUM_CH = 8,
   parameter int DATA_W = 32,
   parameter int GAIN_W = 16,
   parameter int FRAC_W = 14,
   parameter int STEP   = 1024
) (
   input logic CLK,
   input logic RESET,
   multichannel_gain_ramp_if.slave bus
);
   localparam int PROD_W = DATA_W + GAIN_W + 1;
   localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
   localparam logic [GAIN_W:0]  STEP_EXT = (GAIN_W + 1)'(STEP);
   localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] SAT_MIN = {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t state_q, state_d;
   logic [IDX_W-1:0]         idx;
   logic                     drain_cnt;
   logic signed [DATA_W-1:0] sample_r [NUM_CH];
   logic [GAIN_W-1:0]        tgt_r    [NUM_CH];
   logic [GAIN_W-1:0]        cur      [NUM_CH];
   logic [NUM_CH-1:0]        mute_r;
   logic signed [DATA_W-1:0] shadow   [NUM_CH];
   logic signed [PROD_W-1:0] smp_ext, gain_ext, prod_d, prod_q, shifted;
   logic [IDX_W-1:0]         prod_idx;
   logic                     prod_vld;
   logic signed [DATA_W-1:0] sat_res;
   logic [GAIN_W:0]          cur_ext, tgt_ext, cur_next_ext;
   logic [GAIN_W-1:0]        cur_next;
   logic [NUM_CH*DATA_W-1:0] vol_q;
   logic                     out_valid_q, overrun_q, busy;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid) state_d = ISSUE;
         ISSUE:   if (idx == LAST_IDX) state_d = DRAIN;
         DRAIN:   if (drain_cnt) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Ramp is computed one bit wider than the gain so cur+STEP can't wrap before clamping.
   always_comb begin
      cur_ext      = {1'b0, cur[idx]};
      tgt_ext      = mute_r[idx] ? '0 : {1'b0, tgt_r[idx]};
      cur_next_ext = cur_ext;
      if (cur_ext < tgt_ext) begin
         cur_next_ext = cur_ext + STEP_EXT;
         if (cur_next_ext > tgt_ext) cur_next_ext = tgt_ext;
      end else if (cur_ext > tgt_ext) begin
         if ((cur_ext - tgt_ext) > STEP_EXT) cur_next_ext = cur_ext - STEP_EXT;
         else                                cur_next_ext = tgt_ext;
      end
      cur_next = cur_next_ext[GAIN_W-1:0];
   end

   always_comb begin
      smp_ext  = PROD_W'(sample_r[idx]);
      gain_ext = {{(PROD_W-GAIN_W){1'b0}}, cur[idx]};
      prod_d   = smp_ext * gain_ext;
      shifted  = prod_q >>> FRAC_W;
      if (shifted > SAT_MAX)      sat_res = SAT_MAX[DATA_W-1:0];
      else if (shifted < SAT_MIN) sat_res = SAT_MIN[DATA_W-1:0];
      else                        sat_res = shifted[DATA_W-1:0];
   end

   assign busy = (state_q != IDLE);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         idx         <= '0;
         drain_cnt   <= 1'b0;
         mute_r      <= '0;
         prod_q      <= '0;
         prod_idx    <= '0;
         prod_vld    <= 1'b0;
         vol_q       <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            sample_r[k] <= '0;
            tgt_r[k]    <= '0;
            cur[k]      <= '0;
            shadow[k]   <= '0;
         end
      end else begin
         out_valid_q <= 1'b0;
         prod_vld    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  for (int k = 0; k < NUM_CH; k++) begin
                     sample_r[k] <= bus.sample_in[k*DATA_W +: DATA_W];
                     tgt_r[k]    <= bus.gain_tgt[k*GAIN_W +: GAIN_W];
                  end
                  mute_r    <= bus.mute;
                  idx       <= '0;
                  drain_cnt <= 1'b0;
               end
            end
            ISSUE: begin
               prod_q   <= prod_d;
               prod_idx <= idx;
               prod_vld <= 1'b1;
               cur[idx] <= cur_next;
               idx      <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            DRAIN: drain_cnt <= ~drain_cnt;
            DONE: begin
               for (int k = 0; k < NUM_CH; k++) vol_q[k*DATA_W +: DATA_W] <= shadow[k];
               out_valid_q <= 1'b1;
            end
            default: ;
         endcase
         if (prod_vld) shadow[prod_idx] <= sat_res;
         // A new overrun takes priority over a simultaneous clear.
         if (bus.in_valid && busy)  overrun_q <= 1'b1;
         else if (bus.clr_overrun) overrun_q <= 1'b0;
      end
   end

   assign bus.vol_out   = vol_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy;
   assign bus.overrun   = overrun_q;
endmodule
